// File: rtl/id_ex_operand_stage_if.sv
// ID/EX stage bus: decoded ID fields, MEM/WB forward buses and the EX-side outputs.
// The master drives ID fields, pipeline control and forward buses; the slave
// (the ID/EX stage) drives the EX-side outputs.
interface id_ex_operand_stage_if #(
    parameter int XLEN   = 32,
    parameter int FUNC_W = 4
);
    // Pipeline control
    logic              stall;
    logic              flush;

    // Decoded ID fields
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [4:0]        id_rs1_addr;
    logic [4:0]        id_rs2_addr;
    logic [4:0]        id_rd_addr;
    logic [FUNC_W-1:0] id_alu_func;
    logic [1:0]        id_op1_sel;
    logic [1:0]        id_op2_sel;
    logic              id_reg_write;

    // Forward buses from later stages
    logic              mem_fwd_en;
    logic [4:0]        mem_fwd_rd;
    logic [XLEN-1:0]   mem_fwd_data;
    logic              wb_fwd_en;
    logic [4:0]        wb_fwd_rd;
    logic [XLEN-1:0]   wb_fwd_data;

    // EX-side outputs
    logic              ex_valid;
    logic [XLEN-1:0]   ex_op1;
    logic [XLEN-1:0]   ex_op2;
    logic [FUNC_W-1:0] ex_alu_func;
    logic [XLEN-1:0]   ex_store_data;
    logic [XLEN-1:0]   ex_pc;
    logic [4:0]        ex_rd_addr;
    logic              ex_reg_write;

    modport master (
        output stall, flush,
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
        output id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_func,
        output id_op1_sel, id_op2_sel, id_reg_write,
        output mem_fwd_en, mem_fwd_rd, mem_fwd_data,
        output wb_fwd_en, wb_fwd_rd, wb_fwd_data,
        input  ex_valid, ex_op1, ex_op2, ex_alu_func, ex_store_data,
        input  ex_pc, ex_rd_addr, ex_reg_write
    );

    modport slave (
        input  stall, flush,
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
        input  id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_func,
        input  id_op1_sel, id_op2_sel, id_reg_write,
        input  mem_fwd_en, mem_fwd_rd, mem_fwd_data,
        input  wb_fwd_en, wb_fwd_rd, wb_fwd_data,
        output ex_valid, ex_op1, ex_op2, ex_alu_func, ex_store_data,
        output ex_pc, ex_rd_addr, ex_reg_write
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding.
// Captures decoded fields each edge (flush > stall > load). While stalled the
// source data registers reload with their forwarded values, so a producer that
// retires during the stall is still seen once the stall lifts. Operand
// selection is applied after forwarding; ex_store_data is always forwarded rs2.
module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int FUNC_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    id_ex_operand_stage_if.slave  bus
);
    localparam int NSRC = 2;  // source 0 = rs1, source 1 = rs2

    // Pipeline registers
    logic              valid_q,     valid_d;
    logic [XLEN-1:0]   pc_q,        pc_d;
    logic [XLEN-1:0]   imm_q,       imm_d;
    logic [4:0]        rd_addr_q,   rd_addr_d;
    logic [FUNC_W-1:0] alu_func_q,  alu_func_d;
    logic [1:0]        op1_sel_q,   op1_sel_d;
    logic [1:0]        op2_sel_q,   op2_sel_d;
    logic              reg_write_q, reg_write_d;
    logic [4:0]        rs_addr_q [NSRC];
    logic [4:0]        rs_addr_d [NSRC];
    logic [XLEN-1:0]   rs_data_q [NSRC];
    logic [XLEN-1:0]   rs_data_d [NSRC];

    // ID-side source fields gathered per source index
    logic [4:0]        id_rs_addr [NSRC];
    logic [XLEN-1:0]   id_rs_data [NSRC];

    // Forwarded source values and selected operands
    logic [XLEN-1:0]   fwd_data [NSRC];
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;

    assign id_rs_addr[0] = bus.id_rs1_addr;
    assign id_rs_addr[1] = bus.id_rs2_addr;
    assign id_rs_data[0] = bus.id_rs1_data;
    assign id_rs_data[1] = bus.id_rs2_data;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_fwd
            // Forward mux: MEM beats WB beats registered data; x0 never forwards
            always_comb begin
                fwd_data[gi] = rs_data_q[gi];
                if (rs_addr_q[gi] != 5'd0) begin
                    if (bus.mem_fwd_en && (bus.mem_fwd_rd == rs_addr_q[gi])) begin
                        fwd_data[gi] = bus.mem_fwd_data;
                    end else if (bus.wb_fwd_en && (bus.wb_fwd_rd == rs_addr_q[gi])) begin
                        fwd_data[gi] = bus.wb_fwd_data;
                    end
                end
            end
        end
    endgenerate

    // Next-state: flush loads a bubble, stall holds control and refreshes data, else load
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        rd_addr_d   = rd_addr_q;
        alu_func_d  = alu_func_q;
        op1_sel_d   = op1_sel_q;
        op2_sel_d   = op2_sel_q;
        reg_write_d = reg_write_q;
        for (int i = 0; i < NSRC; i++) begin
            rs_addr_d[i] = rs_addr_q[i];
            rs_data_d[i] = rs_data_q[i];
        end

        if (bus.flush) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            imm_d       = '0;
            rd_addr_d   = '0;
            alu_func_d  = '0;
            op1_sel_d   = '0;
            op2_sel_d   = '0;
            reg_write_d = 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                rs_addr_d[i] = '0;
                rs_data_d[i] = '0;
            end
        end else if (bus.stall) begin
            // Capture whatever is being forwarded now so it outlives the producer
            for (int i = 0; i < NSRC; i++) begin
                rs_data_d[i] = fwd_data[i];
            end
        end else begin
            valid_d     = bus.id_valid;
            pc_d        = bus.id_pc;
            imm_d       = bus.id_imm;
            rd_addr_d   = bus.id_rd_addr;
            alu_func_d  = bus.id_alu_func;
            op1_sel_d   = bus.id_op1_sel;
            op2_sel_d   = bus.id_op2_sel;
            reg_write_d = bus.id_reg_write & bus.id_valid;
            for (int i = 0; i < NSRC; i++) begin
                rs_addr_d[i] = id_rs_addr[i];
                rs_data_d[i] = id_rs_data[i];
            end
        end
    end

    // Pipeline register bank, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            rd_addr_q   <= '0;
            alu_func_q  <= '0;
            op1_sel_q   <= '0;
            op2_sel_q   <= '0;
            reg_write_q <= 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                rs_addr_q[i] <= '0;
                rs_data_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            rd_addr_q   <= rd_addr_d;
            alu_func_q  <= alu_func_d;
            op1_sel_q   <= op1_sel_d;
            op2_sel_q   <= op2_sel_d;
            reg_write_q <= reg_write_d;
            for (int i = 0; i < NSRC; i++) begin
                rs_addr_q[i] <= rs_addr_d[i];
                rs_data_q[i] <= rs_data_d[i];
            end
        end
    end

    // Operand select after forwarding; reserved codes yield zero
    always_comb begin
        op1 = '0;
        op2 = '0;
        case (op1_sel_q)
            2'b00:   op1 = fwd_data[0];
            2'b01:   op1 = pc_q;
            default: op1 = '0;
        endcase
        case (op2_sel_q)
            2'b00:   op2 = fwd_data[1];
            2'b01:   op2 = imm_q;
            2'b10:   op2 = XLEN'(4);
            default: op2 = '0;
        endcase
    end

    assign bus.ex_valid      = valid_q;
    assign bus.ex_op1        = op1;
    assign bus.ex_op2        = op2;
    assign bus.ex_alu_func   = alu_func_q;
    assign bus.ex_store_data = fwd_data[1];
    assign bus.ex_pc         = pc_q;
    assign bus.ex_rd_addr    = rd_addr_q;
    assign bus.ex_reg_write  = reg_write_q & valid_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, pass-through, operand select,
// forward priority, x0 guard, stall refresh and flush/stall interaction.
module tb_id_ex_operand_stage;
    localparam int XLEN   = 32;
    localparam int FUNC_W = 4;
    localparam logic [FUNC_W-1:0] FN_ADD = 4'd3;
    localparam logic [FUNC_W-1:0] FN_SUB = 4'd8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    id_ex_operand_stage_if #(.XLEN(XLEN), .FUNC_W(FUNC_W)) bus ();

    id_ex_operand_stage #(.XLEN(XLEN), .FUNC_W(FUNC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        $display("check %-22s got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance past the next rising edge, landing away from it
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_instr(input logic v, input logic [31:0] pc,
                             input logic [4:0] rs1, input logic [31:0] d1,
                             input logic [4:0] rs2, input logic [31:0] d2,
                             input logic [31:0] imm, input logic [4:0] rd,
                             input logic [FUNC_W-1:0] fn, input logic [1:0] s1,
                             input logic [1:0] s2, input logic rw);
        bus.id_valid     = v;
        bus.id_pc        = pc;
        bus.id_rs1_addr  = rs1;
        bus.id_rs1_data  = d1;
        bus.id_rs2_addr  = rs2;
        bus.id_rs2_data  = d2;
        bus.id_imm       = imm;
        bus.id_rd_addr   = rd;
        bus.id_alu_func  = fn;
        bus.id_op1_sel   = s1;
        bus.id_op2_sel   = s2;
        bus.id_reg_write = rw;
    endtask

    task automatic fwd_off();
        bus.mem_fwd_en   = 1'b0;
        bus.mem_fwd_rd   = 5'd0;
        bus.mem_fwd_data = '0;
        bus.wb_fwd_en    = 1'b0;
        bus.wb_fwd_rd    = 5'd0;
        bus.wb_fwd_data  = '0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n     = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_instr(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 4'd0, 2'b00, 2'b00, 1'b0);
        fwd_off();

        // Reset state
        #1;
        check("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
        check("rst_op1", bus.ex_op1, 32'd0);
        check("rst_op2", bus.ex_op2, 32'd0);
        tick();
        rst_n = 1'b1;

        // Pass-through: op1=rs1 data, op2=imm
        set_instr(1'b1, 32'h100, 5'd1, 32'd5, 5'd2, 32'd9, 32'd7, 5'd5, FN_ADD, 2'b00, 2'b01, 1'b1);
        tick();
        check("pt_op1", bus.ex_op1, 32'd5);
        check("pt_op2", bus.ex_op2, 32'd7);
        check("pt_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("pt_func", {28'd0, bus.ex_alu_func}, 32'd3);
        check("pt_pc", bus.ex_pc, 32'h100);
        check("pt_rd", {27'd0, bus.ex_rd_addr}, 32'd5);
        check("pt_reg_write", {31'd0, bus.ex_reg_write}, 32'd1);
        check("pt_store", bus.ex_store_data, 32'd9);

        // op1=pc, op2=const 4
        set_instr(1'b1, 32'h204, 5'd1, 32'd5, 5'd2, 32'd9, 32'd7, 5'd6, FN_SUB, 2'b01, 2'b10, 1'b1);
        tick();
        check("sel_pc_op1", bus.ex_op1, 32'h204);
        check("sel_c4_op2", bus.ex_op2, 32'd4);

        // Zero / reserved selects; invalid instruction suppresses reg_write
        set_instr(1'b0, 32'h208, 5'd1, 32'd5, 5'd2, 32'd9, 32'd7, 5'd7, FN_ADD, 2'b10, 2'b11, 1'b1);
        tick();
        check("sel_zero_op1", bus.ex_op1, 32'd0);
        check("sel_rsv_op2", bus.ex_op2, 32'd0);
        check("inv_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("inv_reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
        set_instr(1'b1, 32'h20c, 5'd1, 32'd5, 5'd2, 32'd9, 32'd7, 5'd7, FN_ADD, 2'b11, 2'b00, 1'b1);
        tick();
        check("sel_rsv_op1", bus.ex_op1, 32'd0);

        // Forward priority on rs1 = x3
        set_instr(1'b1, 32'h300, 5'd3, 32'h11, 5'd4, 32'h22, 32'h50, 5'd8, FN_ADD, 2'b00, 2'b01, 1'b1);
        tick();
        bus.mem_fwd_en = 1'b1; bus.mem_fwd_rd = 5'd3; bus.mem_fwd_data = 32'hAA;
        bus.wb_fwd_en  = 1'b1; bus.wb_fwd_rd  = 5'd3; bus.wb_fwd_data  = 32'hBB;
        #1;
        check("fwd_mem_over_wb", bus.ex_op1, 32'hAA);
        bus.mem_fwd_en = 1'b0;
        #1;
        check("fwd_wb", bus.ex_op1, 32'hBB);
        bus.wb_fwd_en = 1'b0;
        #1;
        check("fwd_none", bus.ex_op1, 32'h11);
        // rs2 forward reaches store data while op2 stays on imm
        bus.mem_fwd_en = 1'b1; bus.mem_fwd_rd = 5'd4; bus.mem_fwd_data = 32'hC0DE;
        #1;
        check("fwd_store", bus.ex_store_data, 32'hC0DE);
        check("fwd_op2_imm", bus.ex_op2, 32'h50);
        check("fwd_rd_mismatch", bus.ex_op1, 32'h11);
        fwd_off();

        // x0 guard
        set_instr(1'b1, 32'h400, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd9, FN_ADD, 2'b00, 2'b00, 1'b1);
        tick();
        bus.mem_fwd_en = 1'b1; bus.mem_fwd_rd = 5'd0; bus.mem_fwd_data = 32'hFFFF_FFFF;
        bus.wb_fwd_en  = 1'b1; bus.wb_fwd_rd  = 5'd0; bus.wb_fwd_data  = 32'hFFFF_FFFF;
        #1;
        check("x0_op1", bus.ex_op1, 32'd0);
        check("x0_op2", bus.ex_op2, 32'd0);
        fwd_off();

        // Stall refresh on rs2 = x6
        set_instr(1'b1, 32'h500, 5'd1, 32'h1, 5'd6, 32'h0, 32'h0, 5'd10, FN_ADD, 2'b00, 2'b00, 1'b1);
        tick();
        bus.stall = 1'b1;
        set_instr(1'b1, 32'h504, 5'd2, 32'h2, 5'd7, 32'h77, 32'h0, 5'd11, FN_SUB, 2'b00, 2'b00, 1'b1);
        bus.wb_fwd_en = 1'b1; bus.wb_fwd_rd = 5'd6; bus.wb_fwd_data = 32'h1234;
        tick();
        bus.wb_fwd_en = 1'b0;
        #1;
        check("stall_store", bus.ex_store_data, 32'h1234);
        check("stall_op2", bus.ex_op2, 32'h1234);
        check("stall_rd_hold", {27'd0, bus.ex_rd_addr}, 32'd10);
        check("stall_pc_hold", bus.ex_pc, 32'h500);
        tick();
        check("stall_store_2", bus.ex_store_data, 32'h1234);

        // Flush and stall on the same edge: flush wins
        bus.flush = 1'b1;
        tick();
        check("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("flush_reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
        check("flush_rd", {27'd0, bus.ex_rd_addr}, 32'd0);
        check("flush_func", {28'd0, bus.ex_alu_func}, 32'd0);
        check("flush_store", bus.ex_store_data, 32'd0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        tick();
        check("post_flush_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("post_flush_rd", {27'd0, bus.ex_rd_addr}, 32'd11);
        check("post_flush_store", bus.ex_store_data, 32'h77);
        check("post_flush_func", {28'd0, bus.ex_alu_func}, 32'd8);

        // Asynchronous reset mid-stream, away from any edge
        set_instr(1'b1, 32'h600, 5'd1, 32'd5, 5'd2, 32'd6, 32'd0, 5'd12, FN_ADD, 2'b00, 2'b00, 1'b1);
        tick();
        check("pre_rst_op1", bus.ex_op1, 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("async_rst_reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
        check("async_rst_op1", bus.ex_op1, 32'd0);
        check("async_rst_op2", bus.ex_op2, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_load", bus.ex_op2, 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
